// File: rtl/dogbattle_vga_pkg.sv
// Shared 640x480@60 raster constants, sync polarity encoding and helpers.
package dogbattle_vga_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned VGA_CLK_DIV  = 2;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Level that a sync pulse takes while active.
  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  localparam sync_pol_e VGA_SYNC_POL = SYNC_ACTIVE_LOW;

  // Registered per-pixel control bundle that travels alongside x/y.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic line_start;
    logic frame_start;
    logic vblank_start;
  } vga_ctl_t;

  // Half-open window test lo <= v < hi on raster coordinates.
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/dogbattle_pix_ce_gen.sv
// Pixel clock-enable generator: divides clk50 by CLK_DIV into a registered pulse.
module dogbattle_pix_ce_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk50,
  input  logic rst,
  output logic pix_ce,
  output logic pix_ce_next_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // pix_ce rises on the edge that retires the last divider count.
  assign pix_ce_next_c = (div_cnt == DIV_LAST);

  // Divider counter and the pix_ce flop.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      pix_ce  <= 1'b0;
    end else begin
      div_cnt <= pix_ce_next_c ? '0 : div_cnt + DIV_W'(1);
      pix_ce  <= pix_ce_next_c;
    end
  end

endmodule

// File: rtl/dogbattle_vga_timing.sv
// Raster timing generator: pixel enable, x/y counters, syncs, DE and frame strobes.
module dogbattle_vga_timing
  import dogbattle_vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter sync_pol_e   SYNC_POL = VGA_SYNC_POL
) (
  input  logic               clk50,
  input  logic               rst,
  output logic               pix_ce,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               de,
  output logic               hs,
  output logic               vs,
  output logic               line_start,
  output logic               frame_start,
  output logic               vblank_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_END = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_END = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG   = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG   = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = 1'(SYNC_POL);
  localparam logic SYNC_OFF = ~SYNC_ON;

  localparam vga_ctl_t CTL_RESET = '{
    de:           1'b0,
    hs:           SYNC_OFF,
    vs:           SYNC_OFF,
    line_start:   1'b0,
    frame_start:  1'b0,
    vblank_start: 1'b0
  };

  logic               step_c;
  logic [COORD_W-1:0] x_nxt;
  logic [COORD_W-1:0] y_nxt;
  vga_ctl_t           ctl;
  vga_ctl_t           ctl_nxt;

  dogbattle_pix_ce_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_ce_gen (
    .clk50         (clk50),
    .rst           (rst),
    .pix_ce        (pix_ce),
    .pix_ce_next_c (step_c)
  );

  // Next raster position and the decode of that position, so that the
  // registered syncs/DE/strobes line up with the registered x/y.
  always_comb begin
    x_nxt   = x + COORD_W'(1);
    y_nxt   = y;
    ctl_nxt = CTL_RESET;
    if (x == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y == V_LAST) ? '0 : y + COORD_W'(1);
    end
    ctl_nxt.de           = (x_nxt < H_ACT_END) && (y_nxt < V_ACT_END);
    ctl_nxt.hs           = in_window(x_nxt, HS_BEG, HS_END) ? SYNC_ON : SYNC_OFF;
    ctl_nxt.vs           = in_window(y_nxt, VS_BEG, VS_END) ? SYNC_ON : SYNC_OFF;
    ctl_nxt.line_start   = (x_nxt == '0);
    ctl_nxt.frame_start  = (x_nxt == '0) && (y_nxt == '0);
    ctl_nxt.vblank_start = (x_nxt == '0) && (y_nxt == V_ACT_END);
  end

  // Raster counters and output flops; strobes drop on every non-stepping clock.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      x   <= H_LAST;
      y   <= V_LAST;
      ctl <= CTL_RESET;
    end else if (step_c) begin
      x   <= x_nxt;
      y   <= y_nxt;
      ctl <= ctl_nxt;
    end else begin
      ctl.line_start   <= 1'b0;
      ctl.frame_start  <= 1'b0;
      ctl.vblank_start <= 1'b0;
    end
  end

  assign de           = ctl.de;
  assign hs           = ctl.hs;
  assign vs           = ctl.vs;
  assign line_start   = ctl.line_start;
  assign frame_start  = ctl.frame_start;
  assign vblank_start = ctl.vblank_start;

endmodule

// File: tb/tb_dogbattle_vga_timing.sv
// Directed bench: full-size timing for reset/line checks, a shrunken raster for frame checks.
module tb_dogbattle_vga_timing;
  import dogbattle_vga_pkg::*;

  // Shrunken raster: H 16+2+4+3=25, V 12+2+2+3=19, 950 clocks per frame at CLK_DIV=2.
  localparam int unsigned SH_ACT = 16, SH_FP = 2, SH_SYNC = 4, SH_BP = 3;
  localparam int unsigned SV_ACT = 12, SV_FP = 2, SV_SYNC = 2, SV_BP = 3;

  logic clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  logic rst_a, rst_b;

  logic               a_ce, a_de, a_hs, a_vs, a_ls, a_fs, a_vbs;
  logic [COORD_W-1:0] a_x, a_y;
  logic               b_ce, b_de, b_hs, b_vs, b_ls, b_fs, b_vbs;
  logic [COORD_W-1:0] b_x, b_y;
  logic               c_ce, c_de, c_hs, c_vs, c_ls, c_fs, c_vbs;
  logic [COORD_W-1:0] c_x, c_y;
  logic               d_ce, d_de, d_hs, d_vs, d_ls, d_fs, d_vbs;
  logic [COORD_W-1:0] d_x, d_y;

  dogbattle_vga_timing u_dut_a (
    .clk50(clk50), .rst(rst_a), .pix_ce(a_ce), .x(a_x), .y(a_y), .de(a_de), .hs(a_hs),
    .vs(a_vs), .line_start(a_ls), .frame_start(a_fs), .vblank_start(a_vbs));

  dogbattle_vga_timing #(
    .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
  ) u_dut_b (
    .clk50(clk50), .rst(rst_b), .pix_ce(b_ce), .x(b_x), .y(b_y), .de(b_de), .hs(b_hs),
    .vs(b_vs), .line_start(b_ls), .frame_start(b_fs), .vblank_start(b_vbs));

  dogbattle_vga_timing #(
    .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
    .SYNC_POL(SYNC_ACTIVE_HIGH)
  ) u_dut_c (
    .clk50(clk50), .rst(rst_b), .pix_ce(c_ce), .x(c_x), .y(c_y), .de(c_de), .hs(c_hs),
    .vs(c_vs), .line_start(c_ls), .frame_start(c_fs), .vblank_start(c_vbs));

  dogbattle_vga_timing #(
    .CLK_DIV(1),
    .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
  ) u_dut_d (
    .clk50(clk50), .rst(rst_b), .pix_ce(d_ce), .x(d_x), .y(d_y), .de(d_de), .hs(d_hs),
    .vs(d_vs), .line_start(d_ls), .frame_start(d_fs), .vblank_start(d_vbs));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Clocks from now until the next pix_ce of instance A, bounded.
  task automatic clocks_to_a_ce(output int n);
    n = 0;
    do begin
      @(negedge clk50);
      n++;
    end while (!a_ce && n < 20);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc, last, gaps_bad, hs_low, hs_first, de_cnt, found;
    int ex, ey, first;
    int xy_bad, de_bad, hs_bad, vs_bad, chs_bad, cvs_bad, c_bad, ls_bad;
    int vs_low, vs_ymin, vs_ymax, vbs_cnt, vbs_x, vbs_y, ls_cnt, fs_cnt, wide, off_bad;
    int d_bad;
    logic p_ls, p_fs, p_vbs, hs_on, vs_on;

    // 1. Reset held 5 cycles.
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) @(posedge clk50);
    @(negedge clk50);
    check("rst_x", 32'(a_x), 799);
    check("rst_y", 32'(a_y), 524);
    check("rst_de", 32'(a_de), 0);
    check("rst_hs", 32'(a_hs), 1);
    check("rst_vs", 32'(a_vs), 1);
    check("rst_pix_ce", 32'(a_ce), 0);
    check("rst_strobes", 32'({a_ls, a_fs, a_vbs}), 0);
    check("rst_pol1_hsvs", 32'({c_hs, c_vs}), 0);

    rst_a = 1'b0;
    clocks_to_a_ce(n);
    check("first_ce_latency", 32'(n), 2);
    check("first_x", 32'(a_x), 0);
    check("first_y", 32'(a_y), 0);
    check("first_frame_start", 32'(a_fs), 1);
    check("first_line_start", 32'(a_ls), 1);
    check("first_de", 32'(a_de), 1);

    // 2. One full line on the full-size raster.
    cyc = 0; last = 0; gaps_bad = 0; hs_low = 0; hs_first = 9999; de_cnt = 1;
    while (cyc < 4000) begin
      @(negedge clk50);
      cyc++;
      if (a_ce) begin
        if (cyc - last != 2) gaps_bad++;
        last = cyc;
        if (a_x == '0) break;
        if (!a_hs) begin
          hs_low++;
          if (hs_first == 9999) hs_first = int'(a_x);
        end
        if (a_de) de_cnt++;
      end
    end
    check("line_clocks", 32'(cyc), 1600);
    check("ce_period_bad", 32'(gaps_bad), 0);
    check("hs_low_count", 32'(hs_low), 96);
    check("hs_first_x", 32'(hs_first), 656);
    check("de_count", 32'(de_cnt), 640);
    check("line1_y", 32'(a_y), 1);
    check("line1_strobes", 32'({a_ls, a_fs}), 32'b10);
    @(negedge clk50);
    check("line_start_width", 32'(a_ls), 0);

    // 5. Reset asserted mid-frame at (300,1).
    found = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk50);
      if (a_ce && a_x == 10'd300 && a_y == 10'd1) begin
        found = 1;
        break;
      end
    end
    check("reach_x300", 32'(found), 1);
    rst_a = 1'b1;
    #1;
    check("midrst_x", 32'(a_x), 799);
    check("midrst_y", 32'(a_y), 524);
    check("midrst_ctl", 32'({a_ce, a_de, a_hs, a_vs, a_ls, a_fs, a_vbs}), 32'b0011000);
    @(negedge clk50);
    check("midrst_hold_strobes", 32'({a_ce, a_ls, a_fs, a_vbs}), 0);
    rst_a = 1'b0;
    clocks_to_a_ce(n);
    check("midrst_ce_latency", 32'(n), 2);
    check("midrst_frame_start", 32'({a_fs, a_x, a_y}), 32'({1'b1, 10'd0, 10'd0}));

    // CLK_DIV=1: pix_ce held high, x steps every clock.
    rst_b = 1'b0;
    @(negedge clk50);
    check("div1_first", 32'({d_ce, d_fs, d_x, d_y}), 32'({1'b1, 1'b1, 10'd0, 10'd0}));
    d_bad = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk50);
      if (!d_ce || int'(d_x) != k % 25 || int'(d_y) != k / 25 ||
          d_ls != (k % 25 == 0) || d_fs) d_bad++;
    end
    check("div1_run_bad", 32'(d_bad), 0);

    // 3/4/6. One full frame on the shrunken raster, both polarities.
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      if (b_fs) begin
        found = 1;
        break;
      end
      @(negedge clk50);
    end
    check("small_fs_found", 32'(found), 1);

    ex = 0; ey = 0; first = 1; cyc = 0;
    xy_bad = 0; de_bad = 0; hs_bad = 0; vs_bad = 0; chs_bad = 0; cvs_bad = 0; c_bad = 0;
    ls_bad = 0; vs_low = 0; vs_ymin = 999; vs_ymax = -1; vbs_cnt = 0; vbs_x = -1; vbs_y = -1;
    ls_cnt = 0; fs_cnt = 0; wide = 0; off_bad = 0; de_cnt = 0;
    p_ls = 1'b0; p_fs = 1'b0; p_vbs = 1'b0;
    while (cyc < 3000) begin
      if (!first && b_fs) break;
      if ((b_ls && p_ls) || (b_fs && p_fs) || (b_vbs && p_vbs)) wide++;
      p_ls = b_ls; p_fs = b_fs; p_vbs = b_vbs;
      if ({c_ce, c_x, c_y, c_de, c_ls, c_fs, c_vbs} != {b_ce, b_x, b_y, b_de, b_ls, b_fs, b_vbs})
        c_bad++;
      if (b_ce) begin
        if (!first) begin
          ex++;
          if (ex == 25) begin
            ex = 0;
            ey++;
            if (ey == 19) ey = 0;
          end
        end
        if (int'(b_x) != ex || int'(b_y) != ey) xy_bad++;
        if (b_de != (ex < 16 && ey < 12)) de_bad++;
        if (b_de) de_cnt++;
        hs_on = (ex >= 18 && ex < 22);
        vs_on = (ey >= 14 && ey < 16);
        if (b_hs != !hs_on) hs_bad++;
        if (b_vs != !vs_on) vs_bad++;
        if (c_hs != hs_on) chs_bad++;
        if (c_vs != vs_on) cvs_bad++;
        if (!b_vs) begin
          vs_low++;
          if (ey < vs_ymin) vs_ymin = ey;
          if (ey > vs_ymax) vs_ymax = ey;
        end
        if (b_ls != (ex == 0)) ls_bad++;
        if (b_ls) ls_cnt++;
        if (b_fs) fs_cnt++;
        if (b_vbs) begin
          vbs_cnt++;
          vbs_x = int'(b_x);
          vbs_y = int'(b_y);
        end
      end else if (b_ls || b_fs || b_vbs) begin
        off_bad++;
      end
      first = 0;
      @(negedge clk50);
      cyc++;
    end
    check("frame_clocks", 32'(cyc), 950);
    check("frame_xy_bad", 32'(xy_bad), 0);
    check("frame_de_bad", 32'(de_bad), 0);
    check("frame_de_count", 32'(de_cnt), 192);
    check("frame_hs_bad", 32'(hs_bad), 0);
    check("frame_vs_bad", 32'(vs_bad), 0);
    check("vs_low_count", 32'(vs_low), 50);
    check("vs_low_ymin", 32'(vs_ymin), 14);
    check("vs_low_ymax", 32'(vs_ymax), 15);
    check("vblank_count", 32'(vbs_cnt), 1);
    check("vblank_at", 32'({vbs_x[15:0], vbs_y[15:0]}), 32'({16'd0, 16'd12}));
    check("line_start_count", 32'(ls_cnt), 19);
    check("line_start_bad", 32'(ls_bad), 0);
    check("frame_start_count", 32'(fs_cnt), 1);
    check("strobe_wide", 32'(wide), 0);
    check("strobe_off_ce", 32'(off_bad), 0);
    check("wrap_both", 32'({b_fs, b_ls, b_x, b_y}), 32'({1'b1, 1'b1, 10'd0, 10'd0}));
    check("pol1_hs_bad", 32'(chs_bad), 0);
    check("pol1_vs_bad", 32'(cvs_bad), 0);
    check("pol1_timing_diff", 32'(c_bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
